addsub_pipe: RTL and testbench



---
 rtl/addsub_pipe.sv | 139 +++++++++++++
 tb/tb_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: one WIDTH/STAGES-bit slice is added per stage,
// with a per-stage valid bit and a whole-pipe stall on output back-pressure.
module addsub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [WIDTH-1:0] s_r;
  logic             c_out_r;
  logic             ovf_r;

  // Subtraction is a + ~b + 1: fold the inversion and forced carry-in in up front
  always_comb begin
    b_eff_s = b;
    c0_s    = c_in;
    if (sub) begin
      b_eff_s = ~b;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = b;
      c0_s    = c_in;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign advance_s = ~(out_valid & ~out_ready);
  assign in_ready  = advance_s;
  assign s         = s_r;
  assign c_out     = c_out_r;
  assign overflow  = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // R operand bits are still un-added on entry to stage k
    localparam int R = WIDTH - k * SW;

    logic [R-1:0]          ia_s;
    logic [R-1:0]          ib_s;
    logic                  ic_s;
    logic                  iv_s;
    logic [(k+1)*SW-1:0]   sum_s;
    logic [SW:0]           slice_s;
    logic                  v_r;

    if (k == 0) begin : g_src
      assign ia_s  = a;
      assign ib_s  = b_eff_s;
      assign ic_s  = c0_s;
      assign iv_s  = in_valid;
      assign sum_s = slice_s[SW-1:0];
    end else begin : g_src
      assign ia_s  = g_stage[k-1].g_fwd.a_r;
      assign ib_s  = g_stage[k-1].g_fwd.b_r;
      assign ic_s  = g_stage[k-1].g_fwd.c_r;
      assign iv_s  = g_stage[k-1].v_r;
      assign sum_s = {slice_s[SW-1:0], g_stage[k-1].g_fwd.sum_r};
    end

    assign slice_s = {1'b0, ia_s[SW-1:0]} + {1'b0, ib_s[SW-1:0]} + {{SW{1'b0}}, ic_s};

    // Valid bit travels with its data so bubbles keep their slot
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        v_r <= 1'b0;
      end else if (advance_s) begin
        v_r <= iv_s;
      end else begin
        v_r <= v_r;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [R-SW-1:0]     a_r;
      logic [R-SW-1:0]     b_r;
      logic [(k+1)*SW-1:0] sum_r;
      logic                c_r;

      // Carry forward the upper operand slices, the partial sum and the slice carry
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          a_r   <= {(R-SW){1'b0}};
          b_r   <= {(R-SW){1'b0}};
          sum_r <= {((k+1)*SW){1'b0}};
          c_r   <= 1'b0;
        end else if (advance_s) begin
          a_r   <= ia_s[R-1:SW];
          b_r   <= ib_s[R-1:SW];
          sum_r <= sum_s;
          c_r   <= slice_s[SW];
        end else begin
          a_r   <= a_r;
          b_r   <= b_r;
          sum_r <= sum_r;
          c_r   <= c_r;
        end
      end
    end else begin : g_last
      logic msb_c_s;

      // Carry into the MSB recovered from the MSB sum bit: sum = a ^ b ^ cin
      assign msb_c_s = ia_s[SW-1] ^ ib_s[SW-1] ^ slice_s[SW-1];

      // Final stage registers the visible result
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          s_r     <= {WIDTH{1'b0}};
          c_out_r <= 1'b0;
          ovf_r   <= 1'b0;
        end else if (advance_s) begin
          s_r     <= sum_s;
          c_out_r <= slice_s[SW];
          ovf_r   <= msb_c_s ^ slice_s[SW];
        end else begin
          s_r     <= s_r;
          c_out_r <= c_out_r;
          ovf_r   <= ovf_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench: four pipelines (STAGES 1,2,4,8) share one stimulus stream;
// directed corner cases run against the STAGES=2 instance.
module tb_addsub_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    bit           free;
    int           cyc;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_ready;

  logic [N-1:0] in_ready_w;
  logic [N-1:0] out_valid_w;
  logic [N-1:0] c_out_w;
  logic [N-1:0] ovf_w;
  logic [W-1:0] s_w [N];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   free_phase = 1'b0;
  exp_t q [N][$];
  int   out_cnt [N] = '{default: 0};
  logic [N-1:0] stall_prev = '0;
  logic [W-1:0] s_prev [N];
  logic [N-1:0] c_prev;
  logic [N-1:0] ov_prev;

  logic [W-1:0] bp_a [4] = '{8'h12, 8'hF0, 8'h55, 8'h01};
  logic [W-1:0] bp_b [4] = '{8'h34, 8'h20, 8'hAA, 8'h02};
  logic         bp_c [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic         bp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  for (genvar i = 0; i < N; i++) begin : g_dut
    addsub_pipe #(.WIDTH(W), .STAGES(1 << i)) u_dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .in_valid (in_valid),
      .in_ready (in_ready_w[i]),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sub      (sub),
      .out_valid(out_valid_w[i]),
      .out_ready(out_ready),
      .s        (s_w[i]),
      .c_out    (c_out_w[i]),
      .overflow (ovf_w[i])
    );
  end

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic for {c_out,s}, signed range test for overflow
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    int   fx, fy, sx, sy, ic, full, sres;
    fx = x;
    fy = y;
    sx = $signed(x);
    sy = $signed(y);
    ic = ci;
    if (sb) begin
      full = fx + ((1 << W) - 1 - fy) + 1;
      sres = sx - sy;
    end else begin
      full = fx + fy + ic;
      sres = sx + sy + ic;
    end
    e.s    = full[W-1:0];
    e.c    = full[W];
    e.ov   = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
    e.free = 1'b0;
    e.cyc  = 0;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      for (int i = 0; i < N; i++) begin
        if (Reset) begin
          q[i].delete();
          stall_prev[i] = 1'b0;
        end else begin
          if (stall_prev[i]) begin
            chk($sformatf("d%0d_hold_s", i), s_w[i], s_prev[i]);
            chk($sformatf("d%0d_hold_c", i), c_out_w[i], c_prev[i]);
            chk($sformatf("d%0d_hold_ov", i), ovf_w[i], ov_prev[i]);
          end
          if (out_valid_w[i] && !out_ready)
            chk($sformatf("d%0d_in_ready_stall", i), in_ready_w[i], 1'b0);
          else
            chk($sformatf("d%0d_in_ready_free", i), in_ready_w[i], 1'b1);
          if (out_valid_w[i] && out_ready) begin
            if (q[i].size() == 0) begin
              chk($sformatf("d%0d_spurious_out", i), out_valid_w[i], 1'b0);
            end else begin
              e = q[i].pop_front();
              chk($sformatf("d%0d_s", i), s_w[i], e.s);
              chk($sformatf("d%0d_c_out", i), c_out_w[i], e.c);
              chk($sformatf("d%0d_overflow", i), ovf_w[i], e.ov);
              if (e.free) chk($sformatf("d%0d_latency", i), cyc - e.cyc, 1 << i);
              out_cnt[i]++;
            end
          end
          if (in_valid && in_ready_w[i]) begin
            e      = model(a, b, c_in, sub);
            e.cyc  = cyc;
            e.free = free_phase;
            q[i].push_back(e);
          end
          stall_prev[i] = out_valid_w[i] & ~out_ready;
          s_prev[i]     = s_w[i];
          c_prev[i]     = c_out_w[i];
          ov_prev[i]    = ovf_w[i];
        end
      end
    end
  end

  // Called at posedge+1; the operand is captured on the next edge
  task automatic dir_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sb, input logic [W-1:0] es, input logic ec,
                        input logic eo);
    a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    chk("dir_not_early", out_valid_w[D], 1'b0);
    @(posedge Clock); #1;
    chk("dir_valid", out_valid_w[D], 1'b1);
    chk("dir_s", s_w[D], es);
    chk("dir_c_out", c_out_w[D], ec);
    chk("dir_overflow", ovf_w[D], eo);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin : driver
    int cnt0;
    Reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clock); #1;
    chk("rst_out_valid", out_valid_w[D], 1'b0);
    chk("rst_s", s_w[D], 8'h00);
    chk("rst_c_out", c_out_w[D], 1'b0);
    chk("rst_overflow", ovf_w[D], 1'b0);
    chk("rst_in_ready", in_ready_w[D], 1'b1);
    Reset = 1'b0;

    dir_op(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    dir_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    dir_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    dir_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    idle(3);

    cnt0 = out_cnt[D];
    fork
      begin : src
        bit acc;
        int budget;
        for (int j = 0; j < 4; j++) begin
          a = bp_a[j]; b = bp_b[j]; c_in = bp_c[j]; sub = bp_s[j]; in_valid = 1'b1;
          budget = 0;
          do begin
            @(negedge Clock);
            acc = in_ready_w[D];
            @(posedge Clock); #1;
            budget++;
          end while (!acc && budget < 20);
          if (!acc) chk("bp_src_timeout", budget, 0);
        end
        in_valid = 1'b0;
      end
      begin : sink
        int wait_n;
        wait_n = 0;
        do begin
          @(posedge Clock); #1;
          wait_n++;
        end while (!out_valid_w[D] && wait_n < 10);
        chk("bp_first_result", out_valid_w[D], 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge Clock); #1;
          chk("bp_held_valid", out_valid_w[D], 1'b1);
          chk("bp_held_s", s_w[D], 8'h47);
          chk("bp_in_ready_low", in_ready_w[D], 1'b0);
        end
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_result_count", out_cnt[D] - cnt0, 4);

    a = 8'h21; b = 8'h43; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge Clock); #1;
    a = 8'h99; b = 8'h11; sub = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid_w[D], 1'b0);
    chk("mid_rst_s", s_w[D], 8'h00);
    chk("mid_rst_in_ready", in_ready_w[D], 1'b1);
    repeat (2) @(posedge Clock); #1;
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      chk("post_rst_quiet", out_valid_w[D], 1'b0);
    end
    dir_op(8'h3C, 8'h0A, 1'b0, 1'b1, 8'h32, 1'b1, 1'b0);
    idle(10);

    free_phase = 1'b1;
    repeat (6000) begin
      in_valid = ($urandom_range(0, 9) != 0);
      a = W'($urandom); b = W'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      @(posedge Clock); #1;
    end
    idle(12);
    free_phase = 1'b0;

    repeat (8000) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      a = W'($urandom); b = W'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge Clock); #1;
    end
    out_ready = 1'b1;
    idle(20);
    for (int i = 0; i < N; i++) chk($sformatf("d%0d_drained", i), q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
